instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
Parametrised, synchronous instruction memory for the pipelined MIPS core. It replaces the hard-coded combinational program ROM.
- The program is streamed in at run time over a valid/ready load port, so new programs need no RTL edits.
- The fetch stage reads it with one-cycle registered latency and a stall/hold input.
- Unloaded or illegal addresses return NOP (32'h0), matching the existing default-zero fetch behaviour.

Parameters:
DATA_W, 32, instruction word width in bits
DEPTH, 256, number of instruction words (power of two)
ADDR_W, 8, word-index width; must equal log2(DEPTH)

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
fetch_en  in  1  1 = capture a new fetch this cycle; 0 = stall, hold outputs
fetch_addr  in  32  byte address from PC
instr  out  DATA_W  fetched instruction, registered
instr_valid  out  1  instr holds a RUN-state fetch result
addr_fault  out  1  last fetch was misaligned or out of range, registered
load_start  in  1  pulse: begin a new program load
load_valid  in  1  load beat valid
load_data  in  DATA_W  load beat word
load_last  in  1  final beat of program
load_ready  out  1  block accepts a beat
loading  out  1  high in LOAD state; core holds PC/stalls
load_count  out  ADDR_W+1  number of words in current program

Behaviour:
- Reset values: instr=0, instr_valid=0, addr_fault=0, load_ready=0, loading=0, load_count=0, state=EMPTY. Memory array is not reset.
- States and transitions:
  - EMPTY: moves to LOAD on load_start.
  - LOAD: moves to RUN on an accepted beat with load_last=1, or on acceptance of the beat at index DEPTH-1 (implicit last).
  - RUN: moves to LOAD on load_start.
  - load_start in LOAD restarts the load: write pointer=0, load_count=0.
- LOAD:
  - loading=1 and load_ready=1.
  - Beat accepted when load_valid&load_ready: mem[ptr]<=load_data, ptr<=ptr+1, load_count<=ptr+1.
  - load_start has priority over a beat in the same cycle; that beat is dropped.
  - In EMPTY/RUN: load_ready=0 and beats are ignored.
- Fetch, with 1-cycle latency: on a rising edge with fetch_en=1, outputs update from fetch_addr sampled that edge. With fetch_en=0, instr, instr_valid and addr_fault hold.
- Word index: idx = fetch_addr[ADDR_W+1:2].
- Fault: fetch_addr[1:0]!=0 or fetch_addr[31:ADDR_W+2]!=0 gives addr_fault=1 and instr=0.
- Unloaded word: idx>=load_count gives instr=0, addr_fault=0.
- Otherwise instr=mem[idx] and addr_fault=0.
- instr_valid=1 only for fetches captured in RUN. Fetches captured in EMPTY/LOAD give instr=0, instr_valid=0, addr_fault=0, so the pipeline sees NOPs.
- Read-during-write cannot occur, because writes happen only in LOAD and RUN reads are gated.
- Pointer wrap: after a beat at DEPTH-1 is accepted, state is RUN; no further writes occur and load_count=DEPTH.
- Asynchronous reset mid-load: returns to EMPTY immediately. Partial contents are discarded logically (load_count=0).

Optional Feature:
INSTR_MEM_PARITY_EN
- With the macro: each word stores an extra even-parity bit computed at write. A RUN fetch of a loaded word recomputes parity and drives an extra output port parity_err (1 bit, registered, reset 0, held under stall). On mismatch, instr is forced to 0.
- Without the macro: no parity storage and no parity_err port.

Test Plan:
- Reset then fetch_en=1, addr 0: instr=0, instr_valid=0 while EMPTY; loading=0, load_ready=0.
- load_start, then beats 32'h20040005, 32'h00001026, 32'h0C000008 with last on beat 3 -> load_count=3, state RUN. Fetch 0x0/0x4/0x8 returns those words one cycle later with instr_valid=1.
- RUN fetch 0xC (unloaded) -> instr=0, fault=0. Fetch 0x2 -> fault=1, instr=0. Fetch 0x400 with DEPTH=256 -> fault=1.
- fetch_en=0 for 3 cycles while fetch_addr changes -> instr/instr_valid/addr_fault hold the previous value.
- Stream 256 beats with load_last never asserted -> RUN after beat 256, load_count=256. A 257th beat gets load_ready=0 and is not written.
- Pull reset_n low after 2 of 5 beats -> EMPTY at once, load_count=0. Reload 1 beat 32'hDEADBEEF with last -> fetch 0x0 returns 32'hDEADBEEF.

Source files
------------

// File: rtl/instr_mem_loadable_if.sv
// Bus bundle for instr_mem_loadable: fetch port plus streaming program-load port.
// Optional INSTR_MEM_PARITY_EN adds the parity_err status signal.
interface instr_mem_loadable_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  // Fetch side
  logic              fetch_en;
  logic [31:0]       fetch_addr;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_fault;
  // Load side
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              loading;
  logic [ADDR_W:0]   load_count;
`ifdef INSTR_MEM_PARITY_EN
  logic              parity_err;

  modport master (
    output fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
    input  instr, instr_valid, addr_fault, load_ready, loading, load_count, parity_err
  );

  modport slave (
    input  fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
    output instr, instr_valid, addr_fault, load_ready, loading, load_count, parity_err
  );
`else
  modport master (
    output fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
    input  instr, instr_valid, addr_fault, load_ready, loading, load_count
  );

  modport slave (
    input  fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
    output instr, instr_valid, addr_fault, load_ready, loading, load_count
  );
`endif
endinterface

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory for the pipelined MIPS core.
// Programs stream in over a valid/ready port (EMPTY -> LOAD -> RUN); the fetch
// port has one-cycle registered latency with a stall/hold input and returns
// NOP (0) for unloaded, misaligned or out-of-range addresses.
// Optional feature macro: INSTR_MEM_PARITY_EN (per-word even parity + parity_err).
module instr_mem_loadable #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  instr_mem_loadable_if.slave    bus
);

`ifdef INSTR_MEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MEM_W = DATA_W + PAR_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_en;
  logic [MEM_W-1:0]  wr_word;

  logic [MEM_W-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              misaligned;
  logic              out_of_range;
  logic              word_loaded;
  logic [MEM_W-1:0]  rd_word;

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
`ifdef INSTR_MEM_PARITY_EN
  logic              perr_q, perr_d;
`endif

  // Load-port handshake is a pure function of the state
  assign bus.load_ready = (state_q == ST_LOAD);
  assign bus.loading    = (state_q == ST_LOAD);
  assign bus.load_count = count_q;

  // Stored word carries an even-parity bit above the data when enabled
`ifdef INSTR_MEM_PARITY_EN
  assign wr_word = {^bus.load_data, bus.load_data};
`else
  assign wr_word = bus.load_data;
`endif

  // Load FSM next-state: load_start always wins and (re)opens an empty program
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_EMPTY, ST_RUN: begin
        if (bus.load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (bus.load_start) begin
          ptr_d   = '0;
          count_d = '0;
        end else if (bus.load_valid) begin
          wr_en   = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          count_d = {1'b0, ptr_q} + {{ADDR_W{1'b0}}, 1'b1};
          // Filling the last slot ends the load even without load_last
          if (bus.load_last || (ptr_q == ADDR_W'(DEPTH - 1))) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        ptr_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // Load FSM state, write pointer and program length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Program storage; contents are not reset, validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr_q] <= wr_word;
    end
  end

  // Fetch address decode
  assign idx          = bus.fetch_addr[ADDR_W+1:2];
  assign misaligned   = |bus.fetch_addr[1:0];
  assign out_of_range = |bus.fetch_addr[31:ADDR_W+2];
  assign word_loaded  = ({1'b0, idx} < count_q);
  assign rd_word      = mem[idx];

  // Fetch result select; outputs hold while fetch_en is low
  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
`ifdef INSTR_MEM_PARITY_EN
    perr_d  = perr_q;
`endif
    if (bus.fetch_en) begin
      instr_d = '0;
      valid_d = 1'b0;
      fault_d = 1'b0;
`ifdef INSTR_MEM_PARITY_EN
      perr_d  = 1'b0;
`endif
      // Outside RUN the pipeline only ever sees NOPs
      if (state_q == ST_RUN) begin
        valid_d = 1'b1;
        if (misaligned || out_of_range) begin
          fault_d = 1'b1;
        end else if (word_loaded) begin
`ifdef INSTR_MEM_PARITY_EN
          if (^rd_word) begin
            perr_d = 1'b1;
          end else begin
            instr_d = rd_word[DATA_W-1:0];
          end
`else
          instr_d = rd_word[DATA_W-1:0];
`endif
        end
      end
    end
  end

  // Registered fetch outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
`ifdef INSTR_MEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.addr_fault  = fault_q;
`ifdef INSTR_MEM_PARITY_EN
  assign bus.parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: a small behavioural model
// predicts each fetch result, which is queued at drive time and compared
// when the registered output appears one cycle later.
module tb_instr_mem_loadable;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  instr_mem_loadable_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_mem_loadable #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          ref_cnt;
  int          ref_ptr;
  bit          ref_load;
  bit          ref_run;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t predict(input logic [31:0] a, input string tag);
    exp_t e;
    e.tag   = tag;
    e.instr = '0;
    e.valid = 1'b0;
    e.fault = 1'b0;
    if (ref_run) begin
      e.valid = 1'b1;
      if (a[1:0] != 2'b00 || a[31:ADDR_W+2] != '0) begin
        e.fault = 1'b1;
      end else if (int'(a[ADDR_W+1:2]) < ref_cnt) begin
        e.instr = ref_mem[a[ADDR_W+1:2]];
      end
    end
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".instr"}, 64'(bus.instr), 64'(e.instr));
    check({e.tag, ".valid"}, 64'(bus.instr_valid), 64'(e.valid));
    check({e.tag, ".fault"}, 64'(bus.addr_fault), 64'(e.fault));
`ifdef INSTR_MEM_PARITY_EN
    check({e.tag, ".perr"}, 64'(bus.parity_err), 64'd0);
`endif
  endtask

  task automatic fetch(input logic [31:0] a, input string tag);
    exp_t e;
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = a;
    e = predict(a, tag);
    sb.push_back(e);
    last_exp = e;
    step();
    compare_out();
  endtask

  task automatic stall(input logic [31:0] a, input string tag);
    exp_t e;
    bus.fetch_en   = 1'b0;
    bus.fetch_addr = a;
    e     = last_exp;
    e.tag = tag;
    sb.push_back(e);
    step();
    compare_out();
  endtask

  // One load-port cycle; checks handshake before the edge and length/state after
  task automatic load_cycle(input bit start, input bit valid, input logic [31:0] d,
                            input bit last, input string tag);
    bus.fetch_en   = 1'b0;
    bus.load_start = start;
    bus.load_valid = valid;
    bus.load_data  = d;
    bus.load_last  = last;
    #1;
    check({tag, ".ready"}, 64'(bus.load_ready), 64'(ref_load));
    if (start) begin
      ref_load = 1'b1;
      ref_run  = 1'b0;
      ref_ptr  = 0;
      ref_cnt  = 0;
    end else if (ref_load && valid) begin
      ref_mem[ref_ptr] = d;
      ref_ptr++;
      ref_cnt = ref_ptr;
      if (last || ref_ptr == DEPTH) begin
        ref_load = 1'b0;
        ref_run  = 1'b1;
      end
    end
    step();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    check({tag, ".count"}, 64'(bus.load_count), 64'(ref_cnt));
    check({tag, ".loading"}, 64'(bus.loading), 64'(ref_load));
  endtask

  task automatic model_reset();
    ref_load       = 1'b0;
    ref_run        = 1'b0;
    ref_cnt        = 0;
    ref_ptr        = 0;
    last_exp.instr = '0;
    last_exp.valid = 1'b0;
    last_exp.fault = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.fetch_en   = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    model_reset();
    repeat (2) step();

    // Reset state
    check("rst.instr", 64'(bus.instr), 64'd0);
    check("rst.valid", 64'(bus.instr_valid), 64'd0);
    check("rst.fault", 64'(bus.addr_fault), 64'd0);
    check("rst.ready", 64'(bus.load_ready), 64'd0);
    check("rst.loading", 64'(bus.loading), 64'd0);
    check("rst.count", 64'(bus.load_count), 64'd0);
    reset_n = 1'b1;
    step();

    // Fetch while EMPTY yields NOP, not valid
    fetch(32'h0, "empty_fetch");
    check("empty.loading", 64'(bus.loading), 64'd0);
    check("empty.ready", 64'(bus.load_ready), 64'd0);

    // Open a load, write a junk beat, restart with a concurrent (dropped) beat
    load_cycle(1'b1, 1'b0, 32'h0, 1'b0, "ld_start");
    load_cycle(1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0, "ld_junk");
    load_cycle(1'b1, 1'b1, 32'h1111_1111, 1'b0, "ld_restart");
    load_cycle(1'b0, 1'b1, 32'h2004_0005, 1'b0, "ld_b0");
    load_cycle(1'b0, 1'b1, 32'h0000_1026, 1'b0, "ld_b1");
    load_cycle(1'b0, 1'b1, 32'h0C00_0008, 1'b1, "ld_b2");
    check("prog3.count", 64'(bus.load_count), 64'd3);

    // RUN fetches: loaded, unloaded, misaligned, out of range
    fetch(32'h0, "f_0x0");
    fetch(32'h4, "f_0x4");
    fetch(32'h8, "f_0x8");
    fetch(32'hC, "f_0xC_unloaded");
    fetch(32'h2, "f_0x2_misalign");
    fetch(32'h400, "f_0x400_range");
    fetch(32'h8000_0000, "f_hi_range");

    // Stall holds outputs while the address moves
    fetch(32'h4, "f_pre_stall");
    stall(32'h8, "stall1");
    stall(32'h2, "stall2");
    stall(32'h400, "stall3");
    fetch(32'h2, "f_post_stall");
    stall(32'h0, "stall_fault_hold");

    // Full-depth load with no load_last: implicit end after beat DEPTH-1
    load_cycle(1'b1, 1'b0, 32'h0, 1'b0, "big_start");
    for (int i = 0; i < DEPTH; i++) begin
      load_cycle(1'b0, 1'b1, $urandom, 1'b0, "big_beat");
    end
    check("big.count", 64'(bus.load_count), 64'(DEPTH));
    check("big.loading", 64'(bus.loading), 64'd0);
    load_cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, "big_extra");
    fetch(32'h0, "big_f0");
    fetch(32'h3FC, "big_f255");
    fetch(32'h200, "big_f128");
    fetch(32'h1, "big_misalign");

    // Asynchronous reset in the middle of a load
    load_cycle(1'b1, 1'b0, 32'h0, 1'b0, "rl_start");
    load_cycle(1'b0, 1'b1, 32'h1234_5678, 1'b0, "rl_b0");
    load_cycle(1'b0, 1'b1, 32'h9ABC_DEF0, 1'b0, "rl_b1");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst.loading", 64'(bus.loading), 64'd0);
    check("arst.count", 64'(bus.load_count), 64'd0);
    check("arst.ready", 64'(bus.load_ready), 64'd0);
    check("arst.valid", 64'(bus.instr_valid), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    fetch(32'h0, "arst_empty_fetch");

    // Reload a single word
    load_cycle(1'b1, 1'b0, 32'h0, 1'b0, "re_start");
    load_cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, "re_b0");
    fetch(32'h0, "re_f0");
    fetch(32'h4, "re_f4_unloaded");
    check("re.word", 64'(last_exp.instr), 64'h0);
    fetch(32'h0, "re_f0_again");
    check("re.deadbeef", 64'(bus.instr), 64'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
